// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory responder for the MEM stage load/store port.
// A request seen in IDLE is captured, held for WAIT_CYCLES extra cycles in BUSY,
// performed on the last BUSY cycle, and acknowledged with a one-cycle ack in
// RESP. While a request is outstanding the pipeline is held with stall.
//
// Ports
//   clk       in   1       system clock, rising edge
//   rst       in   1       asynchronous reset, active-low
//   re        in   1       load request
//   we        in   1       store request
//   addr      in   ADDR_W  word address
//   wrt_data  in   DATA_W  store data
//   rd_data   out  DATA_W  load data, held until the next load completes
//   ack       out  1       one-cycle pulse, access complete
//   stall     out  1       (re|we) & ~ack, combinational
//   err       out  1       pulse with ack: out-of-range address or re&we
//   busy      out  1       state != IDLE
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ack,
  output logic              stall,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so the unsigned range compare cannot wrap.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_X  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_capture;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr;
  logic              r_conf;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  logic              w_req;
  logic              w_access;
  logic              w_oor;
  logic [IDX_W-1:0]  w_idx;

  assign w_req    = re | we;
  assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);
  // Range is evaluated on the captured address, full width, unsigned.
  assign w_oor    = ({1'b0, r_addr} >= DEPTH_X);
  assign w_idx    = r_addr[IDX_W-1:0];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = WAIT_X;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and captured request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_conf  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_addr  <= addr;
        r_wdata <= wrt_data;
        // re&we together is performed as a store but still flagged.
        r_wr    <= we;
        r_conf  <= re & we;
      end
    end
  end

  // Load data register: only a completed load changes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (w_access && !r_wr) begin
      r_rd_data <= w_oor ? '0 : r_mem[w_idx];
    end
  end

  // Storage is never cleared; an abandoned access never reaches w_access
  // because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (w_access && r_wr && !w_oor) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign rd_data = r_rd_data;
  assign ack     = (r_state == S_RESP);
  assign err     = ack & (w_oor | r_conf);
  assign stall   = w_req & ~ack;
  assign busy    = (r_state != S_IDLE);

endmodule
